// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HDR  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic [3:0] HdrMarker = 4'hA;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and serializer-side byte handshakes of the UART TX arbiter.
interface uart_tx_arb_if #(
  parameter int unsigned NumReq = 4
);
  logic [NumReq-1:0]      req_valid;
  logic [NumReq-1:0][7:0] req_data;
  logic [NumReq-1:0]      req_last;
  logic [NumReq-1:0]      req_ready;
  logic                   tx_valid;
  logic [7:0]             tx_data;
  logic                   tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from i_last+1.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdxW-1:0]   i_last,
  output logic [IdxW-1:0]   o_idx,
  output logic              o_any
);

  logic found;

  always_comb begin
    int unsigned k;
    logic [IdxW-1:0] k_idx;
    o_idx = '0;
    o_any = |i_req;
    found = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      k     = (32'(i_last) + off) % NumReq;
      k_idx = IdxW'(k);
      if (!found && i_req[k_idx]) begin
        o_idx = k_idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter in front of the UART TX serializer, with stall watchdog.
// Define UART_TX_ARB_HDR_EN to prefix each packet with a {0xA, 0, id} header byte.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NumReq      = 4,
  parameter  int unsigned TimeoutBits = 16,
  localparam int unsigned IdxW        = idx_width(NumReq)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  uart_tx_arb_if.slave           bus,
  input  logic [TimeoutBits-1:0] c_timeout_cyc,
  output logic                   o_busy,
  output logic [IdxW-1:0]        o_grant_id,
  output logic                   o_timeout
);

  arb_state_e             state_q, state_d;
  logic [IdxW-1:0]        grant_q, grant_d;
  logic [TimeoutBits-1:0] wd_q, wd_d;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_any;
  logic                   g_valid;
  logic                   g_last;

  uart_rr_pick #(
    .NumReq (NumReq)
  ) u_pick (
    .i_req  (bus.req_valid),
    .i_last (grant_q),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  assign g_valid = bus.req_valid[grant_q];
  assign g_last  = bus.req_last[grant_q];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    wd_d          = wd_q;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;
    o_timeout     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          wd_d    = '0;
`ifdef UART_TX_ARB_HDR_EN
          state_d = ARB_HDR;
`else
          state_d = ARB_DATA;
`endif
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      ARB_HDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = {HdrMarker, 1'b0, 3'(grant_q)};
        if (bus.tx_ready) begin
          state_d = ARB_DATA;
          wd_d    = '0;
        end
      end
`endif
      ARB_DATA: begin
        bus.tx_valid           = g_valid;
        bus.tx_data            = bus.req_data[grant_q];
        bus.req_ready[grant_q] = bus.tx_ready;
        if (g_valid && bus.tx_ready) begin
          wd_d = '0;
          if (g_last) state_d = ARB_IDLE;
        end else if (!g_valid) begin
          // Only an absent owner counts as a stall; backpressure holds the counter.
          if ((c_timeout_cyc != '0) && (wd_q == c_timeout_cyc - TimeoutBits'(1))) begin
            state_d   = ARB_IDLE;
            o_timeout = 1'b1;
          end else if (wd_q != '1) begin
            wd_d = wd_q + TimeoutBits'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= IdxW'(NumReq - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wd_q    <= wd_d;
    end
  end

  assign o_busy     = (state_q != ARB_IDLE);
  assign o_grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: random packet traffic against a round-robin packet-list model.
module tb_uart_tx_arb;

  localparam int unsigned NumReq      = 4;
  localparam int unsigned TimeoutBits = 16;
  localparam int unsigned IdxW        = 2;
  localparam int unsigned NP          = 3;
  localparam int unsigned ML          = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NumReq(NumReq)) bus ();

  logic [TimeoutBits-1:0] timeout_cyc;
  logic                   busy;
  logic [IdxW-1:0]        grant_id;
  logic                   timeout;

  uart_tx_arb #(
    .NumReq      (NumReq),
    .TimeoutBits (TimeoutBits)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (bus),
    .c_timeout_cyc (timeout_cyc),
    .o_busy        (busy),
    .o_grant_id    (grant_id),
    .o_timeout     (timeout)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [IdxW-1:0] g;
    logic [7:0]      d;
    logic            last;
  } exp_t;

  exp_t sb_q[$];
  bit   mon_en    = 1'b0;
  bit   prev_last = 1'b0;

  int unsigned n_pkt[NumReq];
  int unsigned plen[NumReq][NP];
  logic [7:0]  pbyte[NumReq][NP][ML];
  int unsigned model_last = NumReq - 1;

  function automatic logic [7:0] hdr_of(input int unsigned k);
    return {4'hA, 1'b0, 3'(k)};
  endfunction

  // Whole packets are served in turn, starting after the most recent owner.
  task automatic build_expected();
    int unsigned done[NumReq];
    int unsigned left;
    int unsigned base;
    int unsigned k;
    bit          found;
    left = 0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      done[r] = 0;
      left += n_pkt[r];
    end
    while (left > 0) begin
      found = 1'b0;
      base  = model_last;
      for (int unsigned off = 1; off <= NumReq; off++) begin
        k = (base + off) % NumReq;
        if (!found && done[k] < n_pkt[k]) begin
          found      = 1'b1;
          model_last = k;
`ifdef UART_TX_ARB_HDR_EN
          sb_q.push_back('{g: IdxW'(k), d: hdr_of(k), last: 1'b0});
`endif
          for (int unsigned b = 0; b < plen[k][done[k]]; b++)
            sb_q.push_back('{g: IdxW'(k), d: pbyte[k][done[k]][b],
                             last: (b == plen[k][done[k]] - 1)});
          done[k]++;
          left--;
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_last) chk("gap_after_last", 32'(bus.tx_valid), 32'd0);
        prev_last = 1'b0;
        chk("no_timeout", 32'(timeout), 32'd0);
        if (bus.tx_valid && bus.tx_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", bus.tx_data, $time);
          end else begin
            e = sb_q.pop_front();
            chk("tx_data", 32'(bus.tx_data), 32'(e.d));
            chk("grant_id", 32'(grant_id), 32'(e.g));
            prev_last = e.last;
          end
        end
      end
    end
  end

  task automatic run_traffic(input bit gap_en, input int unsigned rdy_pct,
                             input int unsigned budget);
    int unsigned       pi[NumReq];
    int unsigned       bi[NumReq];
    logic [NumReq-1:0] fire;
    bit                all_done;
    int unsigned       cyc;
    build_expected();
    for (int unsigned r = 0; r < NumReq; r++) begin
      pi[r] = 0;
      bi[r] = 0;
    end
    fire      = '0;
    cyc       = 0;
    all_done  = 1'b0;
    prev_last = 1'b0;
    mon_en    = 1'b1;
    while (!all_done && cyc < budget) begin
      for (int unsigned r = 0; r < NumReq; r++) begin
        if (fire[r]) begin
          bi[r]++;
          if (bi[r] == plen[r][pi[r]]) begin
            pi[r]++;
            bi[r] = 0;
          end
        end
        if (pi[r] >= n_pkt[r]) begin
          bus.req_valid[r] = 1'b0;
          bus.req_last[r]  = 1'b0;
        end else if (fire[r] || !bus.req_valid[r]) begin
          // Gaps only mid-packet so the arbitration order stays deterministic.
          bus.req_valid[r] = !(gap_en && bi[r] > 0 && $urandom_range(3) == 0);
          bus.req_data[r]  = pbyte[r][pi[r]][bi[r]];
          bus.req_last[r]  = (bi[r] == plen[r][pi[r]] - 1);
        end
      end
      bus.tx_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      cyc++;
      all_done = (sb_q.size() == 0);
    end
    if (!all_done) chk("traffic_budget", 32'(sb_q.size()), 32'd0);
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fire(input int unsigned k, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.req_valid[k] && bus.req_ready[k];
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic clear_pkts();
    for (int unsigned r = 0; r < NumReq; r++) n_pkt[r] = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: got running expected finished at %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;
    timeout_cyc   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd3);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // One-cycle latency from valid in IDLE, then reset mid-packet
    @(posedge clk);
    #1;
    bus.req_valid[2] = 1'b1;
    bus.req_data[2]  = 8'h11;
    bus.tx_ready     = 1'b1;
    @(negedge clk);
    chk("lat_idle_valid", 32'(bus.tx_valid), 32'd0);
    chk("lat_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(bus.tx_valid), 32'd1);
    chk("lat_grant", 32'(grant_id), 32'd2);
`ifdef UART_TX_ARB_HDR_EN
    chk("lat_data", 32'(bus.tx_data), 32'h0A2);
`else
    chk("lat_data", 32'(bus.tx_data), 32'h011);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant", 32'(grant_id), 32'd3);
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = NumReq - 1;

    // Requester 2 sends 0x11/0x22/0x33
    clear_pkts();
    n_pkt[2]       = 1;
    plen[2][0]     = 3;
    pbyte[2][0][0] = 8'h11;
    pbyte[2][0][1] = 8'h22;
    pbyte[2][0][2] = 8'h33;
    run_traffic(1'b0, 100, 200);
    chk("s1_grant_kept", 32'(grant_id), 32'd2);
    chk("s1_idle", 32'(busy), 32'd0);

    // Requesters 0 and 1 with back-to-back single-byte packets
    clear_pkts();
    for (int unsigned r = 0; r < 2; r++) begin
      n_pkt[r] = NP;
      for (int unsigned p = 0; p < NP; p++) begin
        plen[r][p]     = 1;
        pbyte[r][p][0] = 8'($urandom);
      end
    end
    run_traffic(1'b0, 100, 300);

    // Random packets on all requesters with gaps and random backpressure
    for (int round = 0; round < 4; round++) begin
      clear_pkts();
      for (int unsigned r = 0; r < NumReq; r++) begin
        n_pkt[r] = $urandom_range(NP, 1);
        for (int unsigned p = 0; p < NP; p++) begin
          plen[r][p] = $urandom_range(ML, 1);
          for (int unsigned b = 0; b < ML; b++) pbyte[r][p][b] = 8'($urandom);
        end
      end
      run_traffic(1'b1, 50, 3000);
    end

    // Watchdog expiry five cycles after the last transfer, requester 1 pending
    timeout_cyc      = 16'd5;
    bus.tx_ready     = 1'b1;
    bus.req_valid[0] = 1'b1;
    bus.req_data[0]  = 8'hA0;
    bus.req_last[0]  = 1'b0;
    wait_fire(0, "to_first_xfer");
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    bus.req_valid[1] = 1'b1;
    bus.req_data[1]  = 8'h77;
    bus.req_last[1]  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("to_pulse_c%0d", i), 32'(timeout), (i == 5) ? 32'd1 : 32'd0);
    end
    chk("to_busy_at_expiry", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_idle_after", 32'(busy), 32'd0);
    chk("to_grant_kept", 32'(grant_id), 32'd0);
    chk("to_pulse_once", 32'(timeout), 32'd0);
    wait_fire(1, "to_next_xfer");
    chk("to_next_grant", 32'(grant_id), 32'd1);
    chk("to_next_data", 32'(bus.tx_data), 32'h077);
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;

    // Backpressure with valid held high never times out
    bus.tx_ready     = 1'b0;
    bus.req_valid[2] = 1'b1;
    bus.req_data[2]  = 8'h5A;
    bus.req_last[2]  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_no_timeout", 32'(timeout), 32'd0);
    end
    chk("bp_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 bus.tx_ready = 1'b1;
    wait_fire(2, "bp_xfer");
    chk("bp_data", 32'(bus.tx_data), 32'h05A);
    @(posedge clk);
    #1 bus.req_valid[2] = 1'b0;

    // Last byte arriving exactly at the expiry cycle wins over the timeout
    bus.req_valid[3] = 1'b1;
    bus.req_data[3]  = 8'hC0;
    bus.req_last[3]  = 1'b0;
    wait_fire(3, "co_first_xfer");
    @(posedge clk);
    #1 bus.req_valid[3] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.req_valid[3] = 1'b1;
    bus.req_data[3]  = 8'hC1;
    bus.req_last[3]  = 1'b1;
    @(negedge clk);
    chk("co_last_xfer", 32'(bus.req_valid[3] && bus.req_ready[3]), 32'd1);
    chk("co_no_timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1 bus.req_valid[3] = 1'b0;
    @(negedge clk);
    chk("co_idle", 32'(busy), 32'd0);
    chk("co_no_timeout_after", 32'(timeout), 32'd0);
    chk("co_grant", 32'(grant_id), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
